// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce and a 4-key history word.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] data
);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_TARGET = 4'(DEBOUNCE_CNT);

  logic [3:0]    rs_meta_reg, rs_reg;
  logic [PW-1:0] pre_reg;
  logic [3:0]    cols_reg;
  logic [1:0]    state_reg;
  logic [3:0]    cnt_reg;
  logic [3:0]    cand_reg;
  logic [3:0]    key_code_reg;
  logic          key_valid_reg;
  logic          key_held_reg;
  logic [15:0]   data_reg;

  logic          tick;
  logic          press;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [3:0]    cnt_inc;
  logic          cnt_done;
  logic          accept;
  logic          repeat_fire;
  logic          fire;
  logic [3:0]    emit_code;
  logic [3:0]    cols_rot;

  assign tick     = (pre_reg == PRE_MAX);
  assign press    = ~&rs_reg;
  assign cnt_inc  = cnt_reg + 4'd1;
  assign cnt_done = (cnt_inc == DB_TARGET);
  assign cols_rot = {cols_reg[2:0], cols_reg[3]};

  always_comb begin
    col_idx = 2'd0;
    case (cols_reg)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Lowest-numbered active row wins when several rows are low.
  always_comb begin
    row_idx = 2'd0;
    if (!rs_reg[0])      row_idx = 2'd0;
    else if (!rs_reg[1]) row_idx = 2'd1;
    else if (!rs_reg[2]) row_idx = 2'd2;
    else if (!rs_reg[3]) row_idx = 2'd3;
  end

  always_comb begin
    accept = 1'b0;
    if (tick && press) begin
      if (state_reg == SCAN && DB_TARGET == 4'd1)
        accept = 1'b1;
      else if (state_reg == DEBOUNCE && row_idx == cand_reg[3:2] && cnt_done)
        accept = 1'b1;
    end
  end

  assign emit_code = (state_reg == SCAN) ? {row_idx, col_idx} : cand_reg;
  assign fire      = accept | repeat_fire;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int            RW         = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_TARGET = RW'(REPEAT_TICKS);

  logic [RW-1:0] rep_reg;
  logic [RW-1:0] rep_inc;

  assign rep_inc     = rep_reg + RW'(1);
  assign repeat_fire = tick && press && (state_reg == HELD) && (rep_inc == REP_TARGET);

  always_ff @(posedge clk) begin
    if (rst)
      rep_reg <= '0;
    else if (accept || (tick && press && state_reg == RELEASE))
      rep_reg <= '0;
    else if (tick && press && state_reg == HELD)
      rep_reg <= repeat_fire ? '0 : rep_inc;
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_meta_reg   <= 4'hF;
      rs_reg        <= 4'hF;
      pre_reg       <= '0;
      cols_reg      <= 4'b1110;
      state_reg     <= SCAN;
      cnt_reg       <= 4'd0;
      cand_reg      <= 4'd0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
      data_reg      <= 16'h0000;
    end else begin
      rs_meta_reg   <= rows;
      rs_reg        <= rs_meta_reg;
      pre_reg       <= tick ? '0 : pre_reg + PW'(1);
      key_valid_reg <= 1'b0;
      if (fire) begin
        key_valid_reg <= 1'b1;
        key_code_reg  <= emit_code;
        data_reg      <= {data_reg[11:0], emit_code};
      end
      if (tick) begin
        case (state_reg)
          SCAN: begin
            if (!press) begin
              cols_reg <= cols_rot;
            end else begin
              cand_reg <= {row_idx, col_idx};
              if (DB_TARGET == 4'd1) begin
                key_held_reg <= 1'b1;
                state_reg    <= HELD;
              end else begin
                cnt_reg   <= 4'd1;
                state_reg <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (press && row_idx == cand_reg[3:2]) begin
              if (cnt_done) begin
                cnt_reg      <= 4'd0;
                key_held_reg <= 1'b1;
                state_reg    <= HELD;
              end else begin
                cnt_reg <= cnt_inc;
              end
            end else begin
              cnt_reg   <= 4'd0;
              cols_reg  <= cols_rot;
              state_reg <= SCAN;
            end
          end
          HELD: begin
            // Only the frozen column is visible, so any low row means "still down".
            if (!press) begin
              if (DB_TARGET == 4'd1) begin
                key_held_reg <= 1'b0;
                cols_reg     <= cols_rot;
                state_reg    <= SCAN;
              end else begin
                cnt_reg   <= 4'd1;
                state_reg <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (press) begin
              cnt_reg   <= 4'd0;
              state_reg <= HELD;
            end else if (cnt_done) begin
              cnt_reg      <= 4'd0;
              key_held_reg <= 1'b0;
              cols_reg     <= cols_rot;
              state_reg    <= SCAN;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          default: state_reg <= SCAN;
        endcase
      end
    end
  end

  assign cols      = cols_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;
  assign data      = data_reg;

endmodule
